phrase_window_buffer: RTL and testbench
=======================================

# phrase_window_buffer

Parametrised capture buffer for played notes. It collects up to DEPTH notes of NOTE_W bits into a newest-first shift window and publishes the window to the emotion classifier. It has two modes: stop-when-full with acknowledge, and continuous sliding window. An idle timeout closes partial phrases. It sits between the note decoder and the phrase feature extractor.

## Interface
- NOTE_W, 6, width of one note code
- DEPTH, 16, number of note slots (≥2)
- CNT_W, $clog2(DEPTH+1), width of count (derived, not overridden)
- TIMEOUT, 1024, idle cycles that close a partial phrase; 0 disables timeout
- clk  in  1  rising-edge clock
- reset_n  in  1  asynchronous, active-low reset
- clear  in  1  synchronous flush of window and state
- slide_mode  in  1  0 = stop-when-full, 1 = sliding window; latched on first accepted note of a phrase
- note_in  in  NOTE_W  note code
- note_valid  in  1  note_in is valid this cycle
- note_ready  out  1  buffer can accept; accept = note_valid & note_ready
- notes_flat  out  NOTE_W*DEPTH  slot k at bits [k*NOTE_W +: NOTE_W]; slot 0 = newest
- count  out  CNT_W  notes held, 0..DEPTH
- full  out  1  count == DEPTH
- phrase_valid  out  1  window is a complete/closed phrase
- phrase_timeout  out  1  phrase was closed by timeout (partial); only meaningful with phrase_valid
- phrase_ack  in  1  consumer has taken the phrase

## Operation
- States: EMPTY, FILL, HOLD, SLIDE.
- EMPTY: count=0, note_ready=1. An accept loads slot 0, sets count=1, latches slide_mode, and moves to FILL.
- FILL: note_ready=1. An accept shifts slot k→k+1 and loads note_in into slot 0. count increments.
  - The accept that makes count==DEPTH moves to HOLD if latched mode=0, or to SLIDE if latched mode=1.
- Idle counter: cleared on every accept. It increments on each FILL cycle without an accept. When it reaches TIMEOUT, the state moves to HOLD with phrase_timeout=1. The count stays partial.
- HOLD: note_ready=0, phrase_valid=1. The window is frozen. phrase_ack zeroes all slots, count, and phrase_timeout, and the state moves to EMPTY.
- SLIDE: note_ready=1, phrase_valid=1, count=DEPTH. Each accept shifts the window and the oldest note is dropped. phrase_ack is ignored. Exit only by clear or reset.
- Slots at index ≥ count always read 0.
- clear has priority over accept and ack. It forces note_ready=0 in the same cycle, zeroes slots, count, and flags, and moves to EMPTY. A note presented with clear is dropped.
- phrase_ack outside HOLD is ignored.
- A slide_mode change during a phrase has no effect until the next EMPTY→FILL transition.

## Timing
- Asynchronous reset (reset_n=0): state EMPTY, all slots 0, count=0, full=0, phrase_valid=0, phrase_timeout=0, note_ready=1, idle counter 0.
- Accept latency: notes_flat and count update at the clock edge of the accept cycle and are visible the next cycle.
- phrase_valid and full rise in the cycle after the DEPTH-th accept.
- Timeout: phrase_valid rises exactly TIMEOUT cycles after the cycle in which the last note first appeared in slot 0, if no further accept occurs.
- After the ack edge: phrase_valid=0, note_ready=1, count=0 in the next cycle.
- note_ready is combinational from state and clear only. It never depends on note_valid.

## Structure
- Package phrase_pkg holds:
  - the state enum (EMPTY, FILL, HOLD, SLIDE);
  - the default NOTE_W and DEPTH constants;
  - the TIMEOUT default.
- Sub-module phrase_shift_reg (NOTE_W, DEPTH) provides the shift, load, and zero functions. It has async active-low reset, shift enable, and sync zero.
- The FSM, count, and idle counter live in the top module.

## Test plan
Parameters for all scenarios: DEPTH=4, NOTE_W=6, TIMEOUT=8.
- Stop mode, notes 1,2,3,4 on consecutive cycles:
  - → notes_flat slots {0..3}={4,3,2,1}, count=4, full=1, phrase_valid=1, note_ready=0.
  - A 5th note is held off.
  - Ack → count=0, slots 0, note_ready=1 next cycle.
- Slide mode, notes 1..6 → phrase_valid=1 after note 4. Final slots {6,5,4,3}, count=4. Ack has no effect.
- Stop mode, notes 7,9, then 8 idle cycles:
  - → phrase_valid=1, phrase_timeout=1, count=2, slots {9,7,0,0}.
  - With TIMEOUT=0, no close ever occurs.
- clear asserted with note_valid=1 during FILL at count=3 → note dropped, count=0, all slots 0, state EMPTY.
- slide_mode toggled 0→1 after note 2 of a phrase → the phrase ends in HOLD. The next phrase after ack runs in SLIDE.
- reset_n pulsed low mid-HOLD, asynchronously between edges → outputs go to reset values immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/phrase_pkg.sv
// Shared types and default sizing for the phrase window buffer.
package phrase_pkg;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        FILL  = 2'd1,
        HOLD  = 2'd2,
        SLIDE = 2'd3
    } state_t;

    localparam int DEF_NOTE_W  = 6;
    localparam int DEF_DEPTH   = 16;
    localparam int DEF_TIMEOUT = 1024;

endpackage

// File: rtl/phrase_shift_reg.sv
// Newest-first note window: slot 0 sits in the low bits, shifting drops the oldest slot.
module phrase_shift_reg #(
    parameter int NOTE_W = 6,
    parameter int DEPTH  = 16
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     zero,
    input  logic                     shift_en,
    input  logic [NOTE_W-1:0]        note_in,
    output logic [NOTE_W*DEPTH-1:0]  notes_flat
);

    logic [NOTE_W*DEPTH-1:0] slots;

    // Empty slots shift in as zero, so slots at index >= count stay zero without masking.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            slots <= '0;
        end else if (zero) begin
            slots <= '0;
        end else if (shift_en) begin
            slots <= {slots[NOTE_W*(DEPTH-1)-1:0], note_in};
        end
    end

    assign notes_flat = slots;

endmodule

// File: rtl/phrase_window_buffer.sv
// Note capture window with stop-when-full/ack and sliding modes plus idle timeout.
// Handshake: a note is taken on a cycle where note_valid & note_ready; note_ready depends only on state and clear.
module phrase_window_buffer
    import phrase_pkg::*;
#(
    parameter int NOTE_W  = DEF_NOTE_W,
    parameter int DEPTH   = DEF_DEPTH,
    parameter int TIMEOUT = DEF_TIMEOUT,
    localparam int CNT_W  = $clog2(DEPTH + 1)
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     clear,
    input  logic                     slide_mode,
    input  logic [NOTE_W-1:0]        note_in,
    input  logic                     note_valid,
    output logic                     note_ready,
    output logic [NOTE_W*DEPTH-1:0]  notes_flat,
    output logic [CNT_W-1:0]         count,
    output logic                     full,
    output logic                     phrase_valid,
    output logic                     phrase_timeout,
    input  logic                     phrase_ack,
    output logic [1:0]               fsm_state
);

    localparam int IDLE_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);

    state_t              state, state_next;
    logic [CNT_W-1:0]    count_next;
    logic [IDLE_W-1:0]   idle, idle_next;
    logic                tmo, tmo_next;
    logic                mode_lat, mode_next;
    logic                accept;
    logic                zero;

    assign note_ready     = !clear && (state != HOLD);
    assign accept         = note_valid && note_ready;
    assign zero           = clear || ((state == HOLD) && phrase_ack);
    assign full           = (count == CNT_W'(DEPTH));
    assign phrase_valid   = (state == HOLD) || (state == SLIDE);
    assign phrase_timeout = tmo;
    assign fsm_state      = state;

    phrase_shift_reg #(
        .NOTE_W (NOTE_W),
        .DEPTH  (DEPTH)
    ) u_shift (
        .clk        (clk),
        .reset_n    (reset_n),
        .zero       (zero),
        .shift_en   (accept),
        .note_in    (note_in),
        .notes_flat (notes_flat)
    );

    always_comb begin
        state_next = state;
        count_next = count;
        idle_next  = idle;
        tmo_next   = tmo;
        mode_next  = mode_lat;
        if (clear) begin
            state_next = EMPTY;
            count_next = '0;
            idle_next  = '0;
            tmo_next   = 1'b0;
        end else begin
            case (state)
                EMPTY: begin
                    if (accept) begin
                        state_next = FILL;
                        count_next = CNT_W'(1);
                        idle_next  = '0;
                        mode_next  = slide_mode;
                    end
                end
                FILL: begin
                    if (accept) begin
                        count_next = count + 1'b1;
                        idle_next  = '0;
                        if (count == CNT_W'(DEPTH - 1)) begin
                            state_next = mode_lat ? SLIDE : HOLD;
                        end
                    end else if (TIMEOUT != 0) begin
                        // This idle cycle is the TIMEOUT-th since the last note landed in slot 0.
                        if (32'(idle) == TIMEOUT - 1) begin
                            state_next = HOLD;
                            tmo_next   = 1'b1;
                            idle_next  = '0;
                        end else begin
                            idle_next = idle + 1'b1;
                        end
                    end
                end
                HOLD: begin
                    if (phrase_ack) begin
                        state_next = EMPTY;
                        count_next = '0;
                        tmo_next   = 1'b0;
                    end
                end
                SLIDE: begin
                    state_next = SLIDE;
                end
                default: begin
                    state_next = EMPTY;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state    <= EMPTY;
            count    <= '0;
            idle     <= '0;
            tmo      <= 1'b0;
            mode_lat <= 1'b0;
        end else begin
            state    <= state_next;
            count    <= count_next;
            idle     <= idle_next;
            tmo      <= tmo_next;
            mode_lat <= mode_next;
        end
    end

endmodule

// File: tb/tb_phrase_window_buffer.sv
// Bench for phrase_window_buffer: queue-based reference window, per-cycle scoreboard.
module tb_phrase_window_buffer;

    localparam int NOTE_W  = 6;
    localparam int DEPTH   = 4;
    localparam int TIMEOUT = 8;
    localparam int CNT_W   = 3;
    localparam int FLAT_W  = NOTE_W * DEPTH;
    localparam int OBS_W   = FLAT_W + CNT_W + 4;

    logic              clk;
    logic              reset_n;
    logic              clear, slide_mode, note_valid, phrase_ack;
    logic [NOTE_W-1:0] note_in;
    logic              note_ready, full, phrase_valid, phrase_timeout;
    logic [FLAT_W-1:0] notes_flat;
    logic [CNT_W-1:0]  count;
    logic [1:0]        fsm_state;

    logic              clear0, slide_mode0, note_valid0, phrase_ack0;
    logic [NOTE_W-1:0] note_in0;
    logic              note_ready0, full0, phrase_valid0, phrase_timeout0;
    logic [FLAT_W-1:0] notes_flat0;
    logic [CNT_W-1:0]  count0;
    logic [1:0]        fsm_state0;

    int total = 0;
    int bad   = 0;
    logic [OBS_W-1:0] exp_q[$];

    int win[$];
    bit frozen, sliding, timed_out, lmode;
    int idle;

    phrase_window_buffer #(.NOTE_W(NOTE_W), .DEPTH(DEPTH), .TIMEOUT(TIMEOUT)) u_dut (
        .clk(clk), .reset_n(reset_n), .clear(clear), .slide_mode(slide_mode),
        .note_in(note_in), .note_valid(note_valid), .note_ready(note_ready),
        .notes_flat(notes_flat), .count(count), .full(full),
        .phrase_valid(phrase_valid), .phrase_timeout(phrase_timeout),
        .phrase_ack(phrase_ack), .fsm_state(fsm_state)
    );

    phrase_window_buffer #(.NOTE_W(NOTE_W), .DEPTH(DEPTH), .TIMEOUT(0)) u_dut0 (
        .clk(clk), .reset_n(reset_n), .clear(clear0), .slide_mode(slide_mode0),
        .note_in(note_in0), .note_valid(note_valid0), .note_ready(note_ready0),
        .notes_flat(notes_flat0), .count(count0), .full(full0),
        .phrase_valid(phrase_valid0), .phrase_timeout(phrase_timeout0),
        .phrase_ack(phrase_ack0), .fsm_state(fsm_state0)
    );

    // clock / reset
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic [OBS_W-1:0] model_obs(bit clr);
        logic [FLAT_W-1:0] f;
        f = '0;
        for (int i = 0; i < win.size(); i++) f[i*NOTE_W +: NOTE_W] = NOTE_W'(win[i]);
        return {f, CNT_W'(win.size()), (win.size() == DEPTH), (frozen || sliding),
                timed_out, (!clr && !frozen)};
    endfunction

    function automatic logic [OBS_W-1:0] dut_obs();
        return {notes_flat, count, full, phrase_valid, phrase_timeout, note_ready};
    endfunction

    task automatic model_reset();
        win.delete();
        frozen = 0; sliding = 0; timed_out = 0; lmode = 0; idle = 0;
    endtask

    task automatic model_update(bit v, int n, bit m, bit a, bit c);
        if (c) begin
            model_reset();
        end else if (frozen) begin
            if (a) begin
                win.delete();
                frozen = 0;
                timed_out = 0;
                idle = 0;
            end
        end else if (v) begin
            if (win.size() == 0) lmode = m;
            win.push_front(n);
            if (win.size() > DEPTH) void'(win.pop_back());
            idle = 0;
            if (!sliding && win.size() == DEPTH) begin
                if (lmode) sliding = 1;
                else frozen = 1;
            end
        end else if (win.size() > 0 && !sliding) begin
            idle++;
            if (TIMEOUT != 0 && idle == TIMEOUT) begin
                frozen = 1;
                timed_out = 1;
                idle = 0;
            end
        end
    endtask

    // driver: called just after a rising edge; holds inputs for one full cycle
    task automatic step(bit v, int n, bit m, bit a, bit c);
        note_valid = v;
        note_in    = NOTE_W'(n);
        slide_mode = m;
        phrase_ack = a;
        clear      = c;
        exp_q.push_back(model_obs(c));
        model_update(v, n, m, a, c);
        @(posedge clk);
        #1;
    endtask

    task automatic chk(string name, logic [OBS_W-1:0] got, logic [OBS_W-1:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h expected=%h", name, got, exp);
        end
    endtask

    // scoreboard monitor
    always @(negedge clk) begin
        logic [OBS_W-1:0] e, g;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            g = dut_obs();
            total++;
            if (g !== e) begin
                bad++;
                $display("FAIL obs t=%0t got flat=%h cnt=%0d full=%b pv=%b pt=%b rdy=%b expected flat=%h cnt=%0d full=%b pv=%b pt=%b rdy=%b",
                         $time, g[OBS_W-1 -: FLAT_W], g[CNT_W+3:4], g[3], g[2], g[1], g[0],
                         e[OBS_W-1 -: FLAT_W], e[CNT_W+3:4], e[3], e[2], e[1], e[0]);
            end
        end
    end

    initial begin
        reset_n = 1'b0;
        clear = 0; slide_mode = 0; note_valid = 0; phrase_ack = 0; note_in = '0;
        clear0 = 0; slide_mode0 = 0; note_valid0 = 0; phrase_ack0 = 0; note_in0 = '0;
        model_reset();
        #22 reset_n = 1'b1;
        @(posedge clk);
        #1;

        step(0, 0, 0, 0, 0);

        // stop mode, fill, held-off note, ack
        for (int i = 1; i <= 4; i++) step(1, i, 0, 0, 0);
        step(1, 5, 0, 0, 0);
        step(0, 0, 0, 0, 0);
        step(0, 0, 0, 1, 0);
        step(0, 0, 0, 0, 0);

        // slide mode, ack ignored, exit by clear
        for (int i = 1; i <= 6; i++) step(1, i, 1, 0, 0);
        step(0, 0, 0, 1, 0);
        step(0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 1);
        step(0, 0, 0, 0, 0);

        // partial phrase closed by idle timeout
        step(1, 7, 0, 0, 0);
        step(1, 9, 0, 0, 0);
        for (int i = 0; i < TIMEOUT + 1; i++) step(0, 0, 0, 0, 0);
        step(0, 0, 0, 1, 0);
        step(0, 0, 0, 0, 0);

        // clear with a note presented at count 3
        for (int i = 0; i < 3; i++) step(1, 10 + i, 0, 0, 0);
        step(1, 33, 0, 0, 1);
        step(0, 0, 0, 0, 0);

        // mode toggled mid-phrase, then next phrase slides
        step(1, 1, 0, 0, 0);
        step(1, 2, 0, 0, 0);
        step(1, 3, 1, 0, 0);
        step(1, 4, 1, 0, 0);
        step(0, 0, 1, 1, 0);
        step(1, 20, 1, 0, 0);
        for (int i = 0; i < 4; i++) step(1, 21 + i, 0, 0, 0);
        step(0, 0, 0, 1, 0);
        step(0, 0, 0, 0, 1);

        // async reset between edges while holding
        for (int i = 0; i < 4; i++) step(1, 40 + i, 0, 0, 0);
        step(0, 0, 0, 0, 0);
        note_valid = 0; clear = 0; phrase_ack = 0;
        #2 reset_n = 1'b0;
        #1 chk("async_reset", dut_obs(), OBS_W'(1));
        model_reset();
        @(posedge clk);
        #3 reset_n = 1'b1;
        @(posedge clk);
        #1;
        step(0, 0, 0, 0, 0);

        // randomized traffic
        for (int i = 0; i < 400; i++) begin
            step(($urandom_range(0, 3) != 0), $urandom_range(0, 63), $urandom_range(0, 1),
                 ($urandom_range(0, 3) == 0), ($urandom_range(0, 40) == 0));
            if ($urandom_range(0, 25) == 0) begin
                for (int k = 0; k < TIMEOUT + 2; k++) step(0, 0, 0, 0, 0);
            end
        end
        step(0, 0, 0, 0, 0);

        // timeout disabled instance never closes a partial phrase
        note_valid0 = 1; note_in0 = 6'd5;
        @(posedge clk); #1;
        note_in0 = 6'd6;
        @(posedge clk); #1;
        note_valid0 = 0;
        repeat (40) @(posedge clk);
        #1;
        chk("no_timeout_pv", OBS_W'(phrase_valid0), OBS_W'(0));
        chk("no_timeout_cnt", OBS_W'(count0), OBS_W'(2));
        chk("no_timeout_flat", OBS_W'(notes_flat0), OBS_W'({6'd5, 6'd6}));

        @(negedge clk);
        #1;
        chk("queue_drained", OBS_W'(exp_q.size()), OBS_W'(0));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
